// File: rtl/dm_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_bus_pkg: shared types, defaults and window helper for the device adapter
// Revision: 1.0
// ----------------------------------------------------------------------------
package dm_bus_pkg;

   localparam int          AdapterLatency  = 3;
   localparam logic [31:0] DefaultBaseAddr = 32'h1A11_0000;
   localparam logic [31:0] DefaultWinSize  = 32'h0000_1000;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        err;
   } dm_bus_req_t;

   typedef struct packed {
      logic we;
      logic err;
   } dm_bus_rsp_t;

   // Compare only the bits above the window offset so the top of the map cannot overflow.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      logic [31:0] mask;
      mask = ~(size - 32'd1);
      return (addr & mask) == (base & mask);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_bus_pipe_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_bus_pipe_stage: valid + payload register; reset clears valid only
// Revision: 1.0
// ----------------------------------------------------------------------------
module dm_bus_pipe_stage #(
   parameter type T = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic valid_i,
   input  T     data_i,
   output logic valid_o,
   output T     data_o
);

   logic r_valid;
   T     r_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (valid_i) begin
         r_data <= data_i;
      end
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule
`default_nettype wire

// File: rtl/dm_device_bus_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_device_bus_adapter: system bus to fixed-latency debug module device port
// Revision: 1.0
// ----------------------------------------------------------------------------
module dm_device_bus_adapter
   import dm_bus_pkg::*;
#(
   parameter int          BusWidth = 32,
   parameter logic [31:0] BaseAddr = DefaultBaseAddr,
   parameter logic [31:0] WinSize  = DefaultWinSize
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  quiesce_i,
   input  logic                  bus_req_i,
   output logic                  bus_gnt_o,
   input  logic                  bus_we_i,
   input  logic [BusWidth-1:0]   bus_addr_i,
   input  logic [BusWidth/8-1:0] bus_be_i,
   input  logic [BusWidth-1:0]   bus_wdata_i,
   output logic                  bus_rvalid_o,
   output logic [BusWidth-1:0]   bus_rdata_o,
   output logic                  bus_err_o,
   output logic                  dev_req_o,
   output logic                  dev_we_o,
   output logic [BusWidth-1:0]   dev_addr_o,
   output logic [BusWidth/8-1:0] dev_be_o,
   output logic [BusWidth-1:0]   dev_wdata_o,
   input  logic [BusWidth-1:0]   dev_rdata_i,
   output logic                  idle_o
);

   dm_bus_req_t           w_req;
   dm_bus_rsp_t           w_s1_in;
   dm_bus_rsp_t           w_s1_data;
   dm_bus_rsp_t           w_s2_data;
   logic                  w_gnt;
   logic                  w_s1_valid;
   logic                  w_s2_valid;
   logic                  r_rvalid;
   logic                  r_err;
   logic [BusWidth-1:0]   r_rdata;
   logic                  r_dev_we;
   logic [BusWidth-1:0]   r_dev_addr;
   logic [BusWidth/8-1:0] r_dev_be;
   logic [BusWidth-1:0]   r_dev_wdata;

   assign w_gnt = rst_ni & bus_req_i & ~quiesce_i;

   always_comb begin
      w_req.we    = bus_we_i;
      w_req.addr  = bus_addr_i;
      w_req.be    = bus_be_i;
      w_req.wdata = bus_wdata_i;
      w_req.err   = ~in_window(bus_addr_i, BaseAddr, WinSize)
                  | (bus_addr_i[1:0] != 2'b00)
                  | (bus_we_i & (bus_be_i == '0));
      w_s1_in.we  = w_req.we;
      w_s1_in.err = w_req.err;
   end

   dm_bus_pipe_stage #(.T(dm_bus_rsp_t)) u_s1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (w_gnt),
      .data_i  (w_s1_in),
      .valid_o (w_s1_valid),
      .data_o  (w_s1_data)
   );

   // Device-side payload only moves for good requests, so it holds across errors and idle cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_dev_we    <= 1'b0;
         r_dev_addr  <= '0;
         r_dev_be    <= '0;
         r_dev_wdata <= '0;
      end else if (w_gnt && !w_req.err) begin
         r_dev_we    <= w_req.we;
         r_dev_addr  <= w_req.addr;
         r_dev_be    <= w_req.be;
         r_dev_wdata <= w_req.wdata;
      end
   end

   dm_bus_pipe_stage #(.T(dm_bus_rsp_t)) u_s2 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (w_s1_valid),
      .data_i  (w_s1_data),
      .valid_o (w_s2_valid),
      .data_o  (w_s2_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_s2_valid;
         r_err    <= w_s2_valid & w_s2_data.err;
         r_rdata  <= (w_s2_valid && !w_s2_data.err && !w_s2_data.we) ? dev_rdata_i : '0;
      end
   end

   assign bus_gnt_o    = w_gnt;
   assign bus_rvalid_o = r_rvalid;
   assign bus_rdata_o  = r_rdata;
   assign bus_err_o    = r_err;
   assign dev_req_o    = w_s1_valid & ~w_s1_data.err;
   assign dev_we_o     = r_dev_we;
   assign dev_addr_o   = r_dev_addr;
   assign dev_be_o     = r_dev_be;
   assign dev_wdata_o  = r_dev_wdata;
   assign idle_o       = ~(w_s1_valid | w_s2_valid | r_rvalid);

endmodule
`default_nettype wire

// File: tb/tb_dm_device_bus_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dm_device_bus_adapter: directed self-checking bench for the device adapter
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_device_bus_adapter;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        quiesce_i = 1'b0;
   logic        bus_req_i = 1'b0;
   logic        bus_we_i = 1'b0;
   logic [31:0] bus_addr_i = '0;
   logic [3:0]  bus_be_i = 4'hF;
   logic [31:0] bus_wdata_i = '0;
   logic [31:0] dev_rdata_i = '0;
   logic        bus_gnt_o, bus_rvalid_o, bus_err_o, dev_req_o, dev_we_o, idle_o;
   logic [31:0] bus_rdata_o, dev_addr_o, dev_wdata_o;
   logic [3:0]  dev_be_o;

   int          checks = 0;
   int          errors = 0;
   logic        use_inv = 1'b0;
   logic [31:0] fixed_rdata = '0;

   dm_device_bus_adapter dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .quiesce_i    (quiesce_i),
      .bus_req_i    (bus_req_i),
      .bus_gnt_o    (bus_gnt_o),
      .bus_we_i     (bus_we_i),
      .bus_addr_i   (bus_addr_i),
      .bus_be_i     (bus_be_i),
      .bus_wdata_i  (bus_wdata_i),
      .bus_rvalid_o (bus_rvalid_o),
      .bus_rdata_o  (bus_rdata_o),
      .bus_err_o    (bus_err_o),
      .dev_req_o    (dev_req_o),
      .dev_we_o     (dev_we_o),
      .dev_addr_o   (dev_addr_o),
      .dev_be_o     (dev_be_o),
      .dev_wdata_o  (dev_wdata_o),
      .dev_rdata_i  (dev_rdata_i),
      .idle_o       (idle_o)
   );

   always #5 clk = ~clk;

   // Fixed-latency device model: data for a request appears the following cycle.
   always @(posedge clk) begin
      dev_rdata_i <= dev_req_o ? (use_inv ? ~dev_addr_o : fixed_rdata) : 32'h0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 32'h1A11_0040; bus_be_i = 4'hF;
      tick(); tick();
      checks++; if (bus_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", bus_gnt_o); end
      checks++; if (bus_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", bus_rvalid_o); end
      checks++; if (bus_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus_rdata_o); end
      checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_err_o); end
      checks++; if (dev_req_o !== 1'b0) begin errors++; $display("FAIL rst_dev_req: got %b want 0", dev_req_o); end
      checks++; if ({dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o} !== 69'h0) begin errors++; $display("FAIL rst_dev_payload: got we=%b addr=%h be=%h wdata=%h want all 0", dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o); end
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle_o); end
      // Request held across reset release is granted in the first cycle out of reset.
      rst_ni = 1'b1;
      #1;
      checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_release_gnt: got %b want 1", bus_gnt_o); end
      tick();
      bus_req_i = 1'b0;
      checks++; if (dev_req_o !== 1'b1) begin errors++; $display("FAIL rst_release_dev_req: got %b want 1", dev_req_o); end
      tick(); tick();
      checks++; if (bus_rvalid_o !== 1'b1) begin errors++; $display("FAIL rst_release_rvalid: got %b want 1", bus_rvalid_o); end
      tick();
   endtask

   task automatic test_read();
      use_inv = 1'b0; fixed_rdata = 32'hDEAD_BEEF;
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 32'h1A11_0800; bus_be_i = 4'hF;
      #1;
      checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", bus_gnt_o); end
      tick();
      bus_req_i = 1'b0;
      checks++; if (dev_req_o !== 1'b1) begin errors++; $display("FAIL rd_dev_req: got %b want 1", dev_req_o); end
      checks++; if (dev_addr_o !== 32'h1A11_0800) begin errors++; $display("FAIL rd_dev_addr: got %h want 1a110800", dev_addr_o); end
      checks++; if (dev_we_o !== 1'b0) begin errors++; $display("FAIL rd_dev_we: got %b want 0", dev_we_o); end
      checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL rd_idle_busy: got %b want 0", idle_o); end
      tick();
      checks++; if (dev_req_o !== 1'b0 || bus_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_n2: got dev_req=%b rvalid=%b want 0 0", dev_req_o, bus_rvalid_o); end
      tick();
      checks++; if (bus_rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", bus_rvalid_o); end
      checks++; if (bus_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", bus_rdata_o); end
      checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", bus_err_o); end
      tick();
      checks++; if (bus_rvalid_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL rd_done: got rvalid=%b idle=%b want 0 1", bus_rvalid_o, idle_o); end
   endtask

   task automatic test_write();
      bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 32'h1A11_0380; bus_be_i = 4'hF; bus_wdata_i = 32'h1234_5678;
      #1;
      checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", bus_gnt_o); end
      tick();
      bus_req_i = 1'b0; bus_we_i = 1'b0;
      checks++; if (dev_req_o !== 1'b1 || dev_we_o !== 1'b1) begin errors++; $display("FAIL wr_dev_req_we: got %b %b want 1 1", dev_req_o, dev_we_o); end
      checks++; if (dev_wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL wr_dev_wdata: got %h want 12345678", dev_wdata_o); end
      checks++; if (dev_addr_o !== 32'h1A11_0380 || dev_be_o !== 4'hF) begin errors++; $display("FAIL wr_dev_addr_be: got %h %h want 1a110380 f", dev_addr_o, dev_be_o); end
      tick(); tick();
      checks++; if (bus_rvalid_o !== 1'b1) begin errors++; $display("FAIL wr_rvalid: got %b want 1", bus_rvalid_o); end
      checks++; if (bus_rdata_o !== 32'h0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL wr_rsp: got rdata=%h err=%b want 0 0", bus_rdata_o, bus_err_o); end
      tick();
   endtask

   task automatic test_errors();
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 32'h1A11_1000; bus_be_i = 4'hF;
      #1;
      checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL err_oow_gnt: got %b want 1", bus_gnt_o); end
      tick();
      bus_addr_i = 32'h1A11_0002;
      #1;
      checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL err_mis_gnt: got %b want 1", bus_gnt_o); end
      checks++; if (dev_req_o !== 1'b0) begin errors++; $display("FAIL err_oow_dev_req: got %b want 0", dev_req_o); end
      tick();
      bus_we_i = 1'b1; bus_be_i = 4'h0; bus_addr_i = 32'h1A11_0004;
      checks++; if (dev_req_o !== 1'b0) begin errors++; $display("FAIL err_mis_dev_req: got %b want 0", dev_req_o); end
      checks++; if (dev_addr_o !== 32'h1A11_0380) begin errors++; $display("FAIL err_dev_addr_hold: got %h want 1a110380", dev_addr_o); end
      tick();
      bus_req_i = 1'b0; bus_we_i = 1'b0; bus_be_i = 4'hF;
      checks++; if (dev_req_o !== 1'b0) begin errors++; $display("FAIL err_be0_dev_req: got %b want 0", dev_req_o); end
      checks++; if ({bus_rvalid_o, bus_err_o, bus_rdata_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_rsp0: got rvalid=%b err=%b rdata=%h want 1 1 0", bus_rvalid_o, bus_err_o, bus_rdata_o); end
      tick();
      checks++; if ({bus_rvalid_o, bus_err_o, bus_rdata_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_rsp1: got rvalid=%b err=%b rdata=%h want 1 1 0", bus_rvalid_o, bus_err_o, bus_rdata_o); end
      tick();
      checks++; if ({bus_rvalid_o, bus_err_o} !== 2'b11) begin errors++; $display("FAIL err_rsp2: got rvalid=%b err=%b want 1 1", bus_rvalid_o, bus_err_o); end
      tick();
      checks++; if (bus_rvalid_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL err_done: got rvalid=%b idle=%b want 0 1", bus_rvalid_o, idle_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      use_inv = 1'b1;
      for (int j = 0; j < 4; j++) addrs[j] = 32'h1A11_0000 + 32'(4 * j);
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = addrs[i];
         end else begin
            bus_req_i = 1'b0;
         end
         #1;
         if (i < 4) begin
            checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, bus_gnt_o); end
         end
         if (i >= 3 && i <= 6) begin
            checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== ~addrs[i-3] || bus_err_o !== 1'b0) begin errors++; $display("FAIL b2b_rsp[%0d]: got rvalid=%b rdata=%h err=%b want 1 %h 0", i - 3, bus_rvalid_o, bus_rdata_o, bus_err_o, ~addrs[i-3]); end
         end
         if (i == 7) begin
            checks++; if (bus_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_tail: got rvalid=%b want 0", bus_rvalid_o); end
         end
         tick();
      end
   endtask

   task automatic test_quiesce();
      logic [31:0] a0, a1;
      a0 = 32'h1A11_0100; a1 = 32'h1A11_0104;
      use_inv = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = (i == 0) ? a0 : a1;
         quiesce_i = (i >= 2);
         #1;
         if (i < 2) begin
            checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL q_gnt[%0d]: got %b want 1", i, bus_gnt_o); end
         end else begin
            checks++; if (bus_gnt_o !== 1'b0) begin errors++; $display("FAIL q_blocked[%0d]: got %b want 0", i, bus_gnt_o); end
         end
         if (i == 3) begin
            checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== ~a0 || dev_req_o !== 1'b0) begin errors++; $display("FAIL q_rsp0: got rvalid=%b rdata=%h dev_req=%b want 1 %h 0", bus_rvalid_o, bus_rdata_o, dev_req_o, ~a0); end
         end
         if (i == 4) begin
            checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== ~a1 || idle_o !== 1'b0) begin errors++; $display("FAIL q_rsp1: got rvalid=%b rdata=%h idle=%b want 1 %h 0", bus_rvalid_o, bus_rdata_o, idle_o, ~a1); end
         end
         if (i >= 5) begin
            checks++; if (bus_rvalid_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL q_idle[%0d]: got rvalid=%b idle=%b want 0 1", i, bus_rvalid_o, idle_o); end
         end
         tick();
      end
      bus_req_i = 1'b0; quiesce_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      use_inv = 1'b0; fixed_rdata = 32'hCAFE_F00D;
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 32'h1A11_0010; bus_be_i = 4'hF;
      tick();
      bus_req_i = 1'b0;
      tick();
      rst_ni = 1'b0;
      #1;
      checks++; if ({bus_rvalid_o, bus_err_o, bus_rdata_o} !== 34'h0) begin errors++; $display("FAIL mid_rsp: got rvalid=%b err=%b rdata=%h want 0 0 0", bus_rvalid_o, bus_err_o, bus_rdata_o); end
      checks++; if ({dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o} !== 70'h0) begin errors++; $display("FAIL mid_dev: got req=%b we=%b addr=%h be=%h wdata=%h want all 0", dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o); end
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", idle_o); end
      tick();
      checks++; if (bus_rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_dropped: got rvalid=%b want 0", bus_rvalid_o); end
      rst_ni = 1'b1;
      bus_req_i = 1'b1; bus_addr_i = 32'h1A11_0020;
      #1;
      checks++; if (bus_gnt_o !== 1'b1) begin errors++; $display("FAIL mid_next_gnt: got %b want 1", bus_gnt_o); end
      tick();
      bus_req_i = 1'b0;
      checks++; if (dev_req_o !== 1'b1 || dev_addr_o !== 32'h1A11_0020) begin errors++; $display("FAIL mid_next_dev: got req=%b addr=%h want 1 1a110020", dev_req_o, dev_addr_o); end
      tick(); tick();
      checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'hCAFE_F00D || bus_err_o !== 1'b0) begin errors++; $display("FAIL mid_next_rsp: got rvalid=%b rdata=%h err=%b want 1 cafef00d 0", bus_rvalid_o, bus_rdata_o, bus_err_o); end
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_errors();
      test_back_to_back();
      test_quiesce();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
